// File: rtl/wb_byte_master_pkg.sv
// Shared types and constants for the byte-stream Wishbone initiator.
package wb_byte_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_BUS      = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE      = 8'h57;
  localparam logic [7:0] CMD_READ       = 8'h52;
  localparam logic [7:0] CMD_CLRERR     = 8'h43;
  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;

endpackage

// File: rtl/wb_byte_master_if.sv
// Command link, response link, Wishbone bus and status flags of wb_byte_master.
interface wb_byte_master_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_ack_i;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o,
           wb_cyc_o, wb_stb_o, busy, err_timeout
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o,
           wb_cyc_o, wb_stb_o, busy, err_timeout
  );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-command Wishbone initiator: parses write/read/clear-error commands, runs one
// classic single cycle with a saturating timeout, and streams back the response bytes.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_byte_master_if.master      bus
);

  localparam logic [15:0] LP_LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_adr;
  logic [7:0]  r_dat;
  logic [7:0]  r_rdata;
  logic [7:0]  r_status;
  logic [7:0]  r_tx_data;
  logic        r_we;
  logic        r_tx_valid;
  logic        r_idx;
  logic        r_err;
  logic [15:0] r_cnt;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_is_cmd;
  logic        w_expire;
  logic        w_last_byte;
  logic [7:0]  w_resp_byte;
  logic        w_in_bus;

  assign w_rx_ready  = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                       (r_state == ST_GET_DATA);
  assign w_rx_fire   = bus.rx_valid && w_rx_ready;
  assign w_is_cmd    = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
  assign w_expire    = (r_cnt == LP_LAST_CNT);
  // A write answers with status only; a read answers data then status.
  assign w_last_byte = r_we || r_idx;
  assign w_resp_byte = w_last_byte ? r_status : r_rdata;
  assign w_in_bus    = (r_state == ST_BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_rx_fire && w_is_cmd) w_state_next = ST_GET_ADDR;
      ST_GET_ADDR: if (w_rx_fire) w_state_next = r_we ? ST_GET_DATA : ST_BUS;
      ST_GET_DATA: if (w_rx_fire) w_state_next = ST_BUS;
      ST_BUS:      if (bus.wb_ack_i || w_expire) w_state_next = ST_RESP;
      ST_RESP:     if (r_tx_valid && bus.tx_ready && w_last_byte) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr      <= '0;
      r_dat      <= '0;
      r_rdata    <= '0;
      r_status   <= '0;
      r_tx_data  <= '0;
      r_we       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_idx      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // Holding the counter at zero outside BUS reloads it on every BUS entry.
      if (r_state != ST_BUS) r_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire && w_is_cmd) r_we <= (bus.rx_data == CMD_WRITE);
          if (w_rx_fire && (bus.rx_data == CMD_CLRERR)) r_err <= 1'b0;
        end
        ST_GET_ADDR: if (w_rx_fire) r_adr <= bus.rx_data;
        ST_GET_DATA: if (w_rx_fire) r_dat <= bus.rx_data;
        ST_BUS: begin
          r_idx <= 1'b0;
          // Ack takes priority over a coincident expiry.
          if (bus.wb_ack_i) begin
            r_status <= STATUS_OK;
            r_rdata  <= bus.wb_dat_i;
          end else if (w_expire) begin
            r_status <= STATUS_TIMEOUT;
            r_rdata  <= 8'h00;
            r_err    <= 1'b1;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_resp_byte;
          end else if (bus.tx_ready) begin
            if (w_last_byte) begin
              r_tx_valid <= 1'b0;
            end else begin
              r_idx     <= 1'b1;
              r_tx_data <= r_status;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready    = w_rx_ready;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.wb_we_o     = r_we && w_in_bus;
  assign bus.wb_cyc_o    = w_in_bus;
  assign bus.wb_stb_o    = w_in_bus;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed and randomized checks of wb_byte_master against a transaction-level model.
module tb_wb_byte_master;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_n = 0;

  wb_byte_master_if bus();

  wb_byte_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] slave_mem [256];
  logic [7:0] exp_mem   [256];
  bit         exp_err = 1'b0;
  int         ack_delay = 0;

  // Slave responder state
  int         stb_cycles = 0;
  int         last_stb = 0;
  int         first_stb = 0;
  logic [7:0] seen_adr, seen_dat;
  logic       seen_we;
  bit         unstable = 1'b0;

  // Receiver state
  logic [7:0] rx_got[$];
  int         first_tx = 0;
  bit         gap_bad = 1'b0;
  bit         hold_bad = 1'b0;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (stb_cycles == 0) begin
        first_stb = cyc_n;
        seen_adr  = bus.wb_adr_o;
        seen_we   = bus.wb_we_o;
        seen_dat  = bus.wb_dat_o;
        unstable  = 1'b0;
      end else if (bus.wb_adr_o !== seen_adr || bus.wb_we_o !== seen_we ||
                   (seen_we && bus.wb_dat_o !== seen_dat)) begin
        unstable = 1'b1;
      end
      bus.wb_ack_i = (stb_cycles == ack_delay);
      bus.wb_dat_i = bus.wb_ack_i ? slave_mem[bus.wb_adr_o] : 8'($urandom);
      if (bus.wb_ack_i && bus.wb_we_o) slave_mem[bus.wb_adr_o] = bus.wb_dat_o;
      stb_cycles++;
    end else begin
      if (stb_cycles != 0) last_stb = stb_cycles;
      stb_cycles   = 0;
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, output int acc_cycle);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    acc_cycle = cyc_n;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic recv(input int n, input int hold);
    int w;
    logic [7:0] held;
    rx_got.delete();
    gap_bad  = 1'b0;
    hold_bad = 1'b0;
    bus.tx_ready = (hold == 0);
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!bus.tx_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!bus.tx_valid) begin
        check("tx_valid_wait", 32'(bus.tx_valid), 32'd1);
        bus.tx_ready = 1'b1;
        return;
      end
      if (k == 0) first_tx = cyc_n;
      if (k > 0 && w != 0) gap_bad = 1'b1;
      if (k == 0 && hold > 0) begin
        held = bus.tx_data;
        for (int h = 0; h < hold; h++) begin
          if (bus.tx_data !== held || bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b1)
            hold_bad = 1'b1;
          @(negedge clk);
        end
        bus.tx_ready = 1'b1;
      end
      rx_got.push_back(bus.tx_data);
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
  endtask

  task automatic do_cmd(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                        input int delay, input int hold, input string name);
    logic [7:0] exp_q[$];
    bit ok;
    int exp_stb, acc, last_acc;
    ok      = (delay < TO);
    exp_stb = ok ? delay + 1 : TO;
    if (is_wr) begin
      if (ok) exp_mem[a] = d;
      exp_q.push_back(ok ? 8'h00 : 8'hEE);
    end else begin
      exp_q.push_back(ok ? exp_mem[a] : 8'h00);
      exp_q.push_back(ok ? 8'h00 : 8'hEE);
    end
    if (!ok) exp_err = 1'b1;
    ack_delay = delay;
    send_byte(is_wr ? 8'h57 : 8'h52, acc);
    send_byte(a, acc);
    if (is_wr) send_byte(d, acc);
    last_acc = acc;
    recv(exp_q.size(), hold);
    check({name, "_len"}, 32'(rx_got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < rx_got.size(); k++)
      check($sformatf("%s_byte%0d", name, k), 32'(rx_got[k]), 32'(exp_q[k]));
    check({name, "_stb_cycles"}, 32'(last_stb), 32'(exp_stb));
    check({name, "_adr"}, 32'(seen_adr), 32'(a));
    check({name, "_we"}, 32'(seen_we), 32'(is_wr));
    if (is_wr) check({name, "_dat"}, 32'(seen_dat), 32'(d));
    check({name, "_stable"}, 32'(unstable), 32'd0);
    check({name, "_stb_latency"}, 32'(first_stb - last_acc), 32'd1);
    check({name, "_tx_latency"}, 32'(first_tx - first_stb), 32'(exp_stb + 1));
    check({name, "_no_gap"}, 32'(gap_bad), 32'd0);
    if (hold > 0) check({name, "_hold_stable"}, 32'(hold_bad), 32'd0);
    check({name, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({name, "_err_timeout"}, 32'(bus.err_timeout), 32'(exp_err));
    $display("txn %-10s %s adr=%02h dat=%02h ack_delay=%0d hold=%0d resp_bytes=%0d",
             name, is_wr ? "WR" : "RD", a, d, delay, hold, rx_got.size());
  endtask

  initial begin
    int acc, w;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      slave_mem[i] = v;
      exp_mem[i]   = v;
    end
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b1, 8'h15, 8'h3C, 1, 0, "t1_write");

    slave_mem[2] = 8'hA7;
    exp_mem[2]   = 8'hA7;
    do_cmd(1'b0, 8'h02, 8'h00, 0, 0, "t2_read");

    do_cmd(1'b0, 8'h30, 8'h00, NEVER, 0, "t3_tmo");
    send_byte(8'h43, acc);
    exp_err = 1'b0;
    check("t3_clrerr", 32'(bus.err_timeout), 32'(exp_err));
    check("t3_clr_busy", 32'(bus.busy), 32'd0);
    $display("txn %-10s CLRERR", "t3_clr");

    send_byte(8'hFF, acc);
    check("t4_junk_busy", 32'(bus.busy), 32'd0);
    $display("txn %-10s JUNK 0xFF", "t4_junk");
    do_cmd(1'b0, 8'h15, 8'h00, 2, 20, "t4_bp");

    ack_delay = NEVER;
    send_byte(8'h52, acc);
    send_byte(8'h40, acc);
    w = 0;
    while (!bus.wb_stb_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("t5_stb_before_rst", 32'(bus.wb_stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("t5_rst_stb", 32'(bus.wb_stb_o), 32'd0);
    check("t5_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn %-10s RESET mid-bus", "t5_reset");
    do_cmd(1'b1, 8'h77, 8'h5A, 0, 0, "t5_write");
    do_cmd(1'b0, 8'h77, 8'h00, 3, 0, "t5_read");

    do_cmd(1'b1, 8'h44, 8'h99, TO - 1, 0, "t6_edge");
    do_cmd(1'b0, 8'h44, 8'h00, TO - 1, 0, "t6_rdback");

    for (int i = 0; i < 14; i++) begin
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
             int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
             $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
